spi_ram_system: RTL and testbench



---
 rtl/spi_ram_system_pkg.sv | 27 ++
 rtl/spi_ram_system_if.sv | 28 ++
 rtl/spi_ram_host.sv | 96 +++++++++
 rtl/spi_ram_master.sv | 95 +++++++++
 rtl/spi_ram_mem.sv | 41 ++++
 rtl/spi_ram_target.sv | 98 +++++++++
 rtl/spi_ram_system.sv | 81 ++++++++
 tb/tb_spi_ram_system.sv | 250 +++++++++++++++++++++++++
 8 files changed

// File: rtl/spi_ram_system_pkg.sv
// Shared constants for the SPI RAM link: command codes, SCLK timing, frame length and the
// master FSM state encoding.
package spi_ram_system_pkg;

  localparam int unsigned DEF_DATA_BIT = 4;
  localparam int unsigned DEF_ADDR_BIT = 3;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] CMD_WR   = 2'b10;

  localparam int unsigned SCLK_HALF = 4;

  function automatic int unsigned frame_len(input int unsigned addr_bit,
                                            input int unsigned data_bit);
    return 2 + addr_bit + data_bit;
  endfunction

  localparam int unsigned FRAME_LEN = frame_len(DEF_ADDR_BIT, DEF_DATA_BIT);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/spi_ram_system_if.sv
// Host-side request/response signals plus the observed SPI bus of the RAM subsystem.
interface spi_ram_system_if #(
  parameter int unsigned DATA_BIT = 4,
  parameter int unsigned ADDR_BIT = 3
) ();

  logic                WR_START;
  logic                RD_START;
  logic [DATA_BIT-1:0] DIN;
  logic [DATA_BIT-1:0] DOUT;
  logic                WR_DONE;
  logic                RD_DONE;
  logic                CSN;
  logic                SCLK;
  logic                MOSI;
  logic                MISO;

  modport master (
    output WR_START, RD_START, DIN,
    input  DOUT, WR_DONE, RD_DONE, CSN, SCLK, MOSI, MISO
  );

  modport slave (
    input  WR_START, RD_START, DIN,
    output DOUT, WR_DONE, RD_DONE, CSN, SCLK, MOSI, MISO
  );

endinterface

// File: rtl/spi_ram_host.sv
// Host front-end: turns start-level rising edges into single SPI transactions on
// auto-incrementing write/read pointers.
module spi_ram_host
  import spi_ram_system_pkg::*;
#(
  parameter int unsigned DATA_BIT = DEF_DATA_BIT,
  parameter int unsigned ADDR_BIT = DEF_ADDR_BIT
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wr_start,
  input  logic                i_rd_start,
  input  logic [DATA_BIT-1:0] i_din,
  output logic [DATA_BIT-1:0] o_dout,
  output logic                o_wr_done,
  output logic                o_rd_done,
  output logic                o_start,
  output logic [1:0]          o_cmd,
  output logic [ADDR_BIT-1:0] o_addr,
  output logic [DATA_BIT-1:0] o_wdata,
  input  logic                i_done,
  input  logic [DATA_BIT-1:0] i_rdata
);

  logic                r_wr_d, r_rd_d, r_busy, r_start;
  logic                r_wr_done, r_rd_done;
  logic [1:0]          r_cmd;
  logic [ADDR_BIT-1:0] r_wptr, r_rptr, r_addr;
  logic [DATA_BIT-1:0] r_wdata, r_dout;
  logic                w_wr_rise, w_rd_rise;

  assign w_wr_rise = i_wr_start & ~r_wr_d;
  assign w_rd_rise = i_rd_start & ~r_rd_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_d    <= 1'b0;
      r_rd_d    <= 1'b0;
      r_busy    <= 1'b0;
      r_start   <= 1'b0;
      r_wr_done <= 1'b0;
      r_rd_done <= 1'b0;
      r_cmd     <= CMD_IDLE;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_dout    <= '0;
    end else begin
      // Edge history always advances, so edges seen while busy are consumed and dropped.
      r_wr_d    <= i_wr_start;
      r_rd_d    <= i_rd_start;
      r_start   <= 1'b0;
      r_wr_done <= 1'b0;
      r_rd_done <= 1'b0;
      if (!r_busy) begin
        if (w_wr_rise) begin
          r_busy  <= 1'b1;
          r_start <= 1'b1;
          r_cmd   <= CMD_WR;
          r_addr  <= r_wptr;
          r_wdata <= i_din;
        end else if (w_rd_rise) begin
          r_busy  <= 1'b1;
          r_start <= 1'b1;
          r_cmd   <= CMD_RD;
          r_addr  <= r_rptr;
          r_wdata <= '0;
        end
      end
      if (i_done) begin
        if (r_cmd == CMD_WR) begin
          r_wr_done <= 1'b1;
          r_wptr    <= r_wptr + 1'b1;
        end else begin
          r_rd_done <= 1'b1;
          r_dout    <= i_rdata;
          r_rptr    <= r_rptr + 1'b1;
        end
      end
      // Stay busy through the DONE cycle; new edges count from the cycle after.
      if (r_wr_done || r_rd_done) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_start   = r_start;
  assign o_cmd     = r_cmd;
  assign o_addr    = r_addr;
  assign o_wdata   = r_wdata;
  assign o_dout    = r_dout;
  assign o_wr_done = r_wr_done;
  assign o_rd_done = r_rd_done;

endmodule

// File: rtl/spi_ram_master.sv
// SPI mode-0 master: serialises one {cmd, addr, data} frame MSB first and captures MISO
// on every SCLK rise; the last DATA_BIT samples are the read data.
module spi_ram_master
  import spi_ram_system_pkg::*;
#(
  parameter int unsigned DATA_BIT = DEF_DATA_BIT,
  parameter int unsigned ADDR_BIT = DEF_ADDR_BIT
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [1:0]          i_cmd,
  input  logic [ADDR_BIT-1:0] i_addr,
  input  logic [DATA_BIT-1:0] i_wdata,
  input  logic                i_miso,
  output logic                o_csn,
  output logic                o_sclk,
  output logic                o_mosi,
  output logic                o_done,
  output logic [DATA_BIT-1:0] o_rdata
);

  localparam int unsigned FLEN  = frame_len(ADDR_BIT, DATA_BIT);
  localparam int unsigned BIT_W = $clog2(FLEN + 1);
  localparam int unsigned DIV_W = $clog2(SCLK_HALF);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FLEN);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);

  logic [2:0]          r_state;
  logic [DIV_W-1:0]    r_div;
  logic [BIT_W-1:0]    r_bit;
  logic [FLEN-1:0]     r_tx;
  logic [DATA_BIT-1:0] r_rx;
  logic                r_csn, r_sclk;
  logic                w_tick, w_timing;

  assign w_tick   = (r_div == DIV_LAST);
  assign w_timing = (r_state == ST_START) || (r_state == ST_SHIFT) || (r_state == ST_STOP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_csn   <= 1'b1;
      r_sclk  <= 1'b0;
    end else begin
      r_div <= (w_timing && !w_tick) ? r_div + 1'b1 : '0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_tx    <= {i_cmd, i_addr, i_wdata};
            r_bit   <= '0;
            r_csn   <= 1'b0;
            r_state <= ST_START;
          end
        end
        // START is the leading SCLK-low half period; from there both share the toggle logic.
        ST_START, ST_SHIFT: begin
          if (w_tick) begin
            if (r_sclk) begin
              r_sclk <= 1'b0;
              r_tx   <= {r_tx[FLEN-2:0], 1'b0};
              if (r_bit == BIT_LAST) begin
                r_state <= ST_STOP;
              end
            end else begin
              r_sclk  <= 1'b1;
              r_rx    <= {r_rx[DATA_BIT-2:0], i_miso};
              r_bit   <= r_bit + 1'b1;
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_csn   <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_csn   = r_csn;
  assign o_sclk  = r_sclk;
  assign o_mosi  = ~r_csn & r_tx[FLEN-1];
  assign o_done  = (r_state == ST_DONE);
  assign o_rdata = r_rx;

endmodule

// File: rtl/spi_ram_mem.sv
// Small synchronous RAM: write on WEN, registered read on REN (1-cycle latency),
// contents cleared by reset.
module spi_ram_mem
  import spi_ram_system_pkg::*;
#(
  parameter int unsigned DATA_BIT = DEF_DATA_BIT,
  parameter int unsigned ADDR_BIT = DEF_ADDR_BIT
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wen,
  input  logic                i_ren,
  input  logic [ADDR_BIT-1:0] i_addr,
  input  logic [DATA_BIT-1:0] i_wdata,
  output logic [DATA_BIT-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_BIT;

  logic [DATA_BIT-1:0] r_mem [DEPTH];
  logic [DATA_BIT-1:0] r_rdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (i_wen) begin
        r_mem[i_addr] <= i_wdata;
      end
      if (i_ren) begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_ram_target.sv
// SPI slave front-end: samples MOSI on SCLK rises seen in the CLK domain and turns the
// decoded frame into one RAM write or read; read data is shifted out on MISO.
module spi_ram_target
  import spi_ram_system_pkg::*;
#(
  parameter int unsigned DATA_BIT = DEF_DATA_BIT,
  parameter int unsigned ADDR_BIT = DEF_ADDR_BIT
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_csn,
  input  logic                i_sclk,
  input  logic                i_mosi,
  output logic                o_miso,
  output logic                o_wen,
  output logic                o_ren,
  output logic [ADDR_BIT-1:0] o_addr,
  output logic [DATA_BIT-1:0] o_wdata,
  input  logic [DATA_BIT-1:0] i_rdata
);

  localparam int unsigned FLEN  = frame_len(ADDR_BIT, DATA_BIT);
  localparam int unsigned HDR   = 2 + ADDR_BIT;
  localparam int unsigned SH_W  = (HDR > DATA_BIT) ? HDR : DATA_BIT;
  localparam int unsigned CNT_W = $clog2(FLEN + 1);
  localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(HDR - 1);
  localparam logic [CNT_W-1:0] CNT_HDR      = CNT_W'(HDR);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(FLEN - 1);

  logic                r_sclk_d, r_wen, r_ren, r_ren_q, r_rd_phase;
  logic [CNT_W-1:0]    r_cnt;
  logic [SH_W-2:0]     r_sh;
  logic [1:0]          r_cmd;
  logic [ADDR_BIT-1:0] r_addr;
  logic [DATA_BIT-1:0] r_wdata, r_tx;
  logic                w_rise, w_fall;
  logic [SH_W-1:0]     w_sh_next;

  assign w_rise    = i_sclk & ~r_sclk_d;
  assign w_fall    = ~i_sclk & r_sclk_d;
  assign w_sh_next = {r_sh, i_mosi};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk_d   <= 1'b0;
      r_wen      <= 1'b0;
      r_ren      <= 1'b0;
      r_ren_q    <= 1'b0;
      r_rd_phase <= 1'b0;
      r_cnt      <= '0;
      r_sh       <= '0;
      r_cmd      <= CMD_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_tx       <= '0;
    end else begin
      r_sclk_d <= i_sclk;
      r_wen    <= 1'b0;
      r_ren    <= 1'b0;
      r_ren_q  <= r_ren;
      if (i_csn) begin
        r_cnt      <= '0;
        r_rd_phase <= 1'b0;
      end else begin
        if (w_rise) begin
          r_sh  <= w_sh_next[SH_W-2:0];
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_HDR_LAST) begin
            r_cmd  <= w_sh_next[ADDR_BIT +: 2];
            r_addr <= w_sh_next[ADDR_BIT-1:0];
            r_ren  <= (w_sh_next[ADDR_BIT +: 2] == CMD_RD);
          end
          if (r_cnt == CNT_LAST) begin
            r_rd_phase <= 1'b0;
            if (r_cmd == CMD_WR) begin
              r_wen   <= 1'b1;
              r_wdata <= w_sh_next[DATA_BIT-1:0];
            end
          end
        end
        // RAM data lands two cycles after REN, well before the first data-phase SCLK rise.
        if (r_ren_q) begin
          r_tx       <= i_rdata;
          r_rd_phase <= 1'b1;
        end else if (w_fall && r_rd_phase && (r_cnt > CNT_HDR)) begin
          r_tx <= {r_tx[DATA_BIT-2:0], 1'b0};
        end
      end
    end
  end

  assign o_miso  = r_rd_phase & r_tx[DATA_BIT-1];
  assign o_wen   = r_wen;
  assign o_ren   = r_ren;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;

endmodule

// File: rtl/spi_ram_system.sv
// Demonstration top: host front-end -> SPI master -> SPI bus -> slave front-end -> RAM,
// with the SPI bus exported for observation.
module spi_ram_system
  import spi_ram_system_pkg::*;
#(
  parameter int unsigned DATA_BIT = DEF_DATA_BIT,
  parameter int unsigned ADDR_BIT = DEF_ADDR_BIT
) (
  input logic              CLK,
  input logic              RSTN,
  spi_ram_system_if.slave  bus
);

  logic                w_start, w_done;
  logic [1:0]          w_cmd;
  logic [ADDR_BIT-1:0] w_host_addr, w_mem_addr;
  logic [DATA_BIT-1:0] w_host_wdata, w_master_rdata, w_mem_wdata, w_mem_rdata;
  logic                w_csn, w_sclk, w_mosi, w_miso, w_wen, w_ren;

  spi_ram_host #(.DATA_BIT(DATA_BIT), .ADDR_BIT(ADDR_BIT)) u_host (
    .i_clk      (CLK),
    .i_rst_n    (RSTN),
    .i_wr_start (bus.WR_START),
    .i_rd_start (bus.RD_START),
    .i_din      (bus.DIN),
    .o_dout     (bus.DOUT),
    .o_wr_done  (bus.WR_DONE),
    .o_rd_done  (bus.RD_DONE),
    .o_start    (w_start),
    .o_cmd      (w_cmd),
    .o_addr     (w_host_addr),
    .o_wdata    (w_host_wdata),
    .i_done     (w_done),
    .i_rdata    (w_master_rdata)
  );

  spi_ram_master #(.DATA_BIT(DATA_BIT), .ADDR_BIT(ADDR_BIT)) u_master (
    .i_clk   (CLK),
    .i_rst_n (RSTN),
    .i_start (w_start),
    .i_cmd   (w_cmd),
    .i_addr  (w_host_addr),
    .i_wdata (w_host_wdata),
    .i_miso  (w_miso),
    .o_csn   (w_csn),
    .o_sclk  (w_sclk),
    .o_mosi  (w_mosi),
    .o_done  (w_done),
    .o_rdata (w_master_rdata)
  );

  spi_ram_target #(.DATA_BIT(DATA_BIT), .ADDR_BIT(ADDR_BIT)) u_target (
    .i_clk   (CLK),
    .i_rst_n (RSTN),
    .i_csn   (w_csn),
    .i_sclk  (w_sclk),
    .i_mosi  (w_mosi),
    .o_miso  (w_miso),
    .o_wen   (w_wen),
    .o_ren   (w_ren),
    .o_addr  (w_mem_addr),
    .o_wdata (w_mem_wdata),
    .i_rdata (w_mem_rdata)
  );

  spi_ram_mem #(.DATA_BIT(DATA_BIT), .ADDR_BIT(ADDR_BIT)) u_mem (
    .i_clk   (CLK),
    .i_rst_n (RSTN),
    .i_wen   (w_wen),
    .i_ren   (w_ren),
    .i_addr  (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_mem_rdata)
  );

  assign bus.CSN  = w_csn;
  assign bus.SCLK = w_sclk;
  assign bus.MOSI = w_mosi;
  assign bus.MISO = w_miso;

endmodule

// File: tb/tb_spi_ram_system.sv
// Directed bench for spi_ram_system: a bus monitor decodes each SPI frame and checks it,
// and DOUT, against expectations queued by the stimulus from a reference RAM model.
module tb_spi_ram_system;
  import spi_ram_system_pkg::*;

  localparam int unsigned DW = 4;
  localparam int unsigned AW = 3;
  localparam int unsigned FL = 2 + AW + DW;

  typedef struct packed {
    logic [FL-1:0] mosi;
    logic [FL-1:0] miso;
  } frame_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  spi_ram_system_if #(.DATA_BIT(DW), .ADDR_BIT(AW)) bus ();

  spi_ram_system #(.DATA_BIT(DW), .ADDR_BIT(AW)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;

  frame_t        exp_q[$];
  logic [DW-1:0] dout_q[$];
  logic [DW-1:0] ref_mem[8];
  logic [AW-1:0] wptr, rptr;

  logic [FL-1:0] mon_mosi, mon_miso;
  int            mon_bits;
  frame_t        mon_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.WR_DONE === 1'b1) wr_cnt <= wr_cnt + 1;
    if (bus.RD_DONE === 1'b1) rd_cnt <= rd_cnt + 1;
  end

  // Frame monitor: frames cut short by reset are ignored.
  initial begin
    forever begin
      @(negedge bus.CSN);
      mon_mosi = '0;
      mon_miso = '0;
      mon_bits = 0;
      while (bus.CSN === 1'b0) begin
        @(posedge bus.SCLK or posedge bus.CSN);
        if (bus.CSN === 1'b0) begin
          mon_mosi = {mon_mosi[FL-2:0], bus.MOSI};
          mon_miso = {mon_miso[FL-2:0], bus.MISO};
          mon_bits++;
        end
      end
      if (rstn === 1'b1) begin
        check("frame_bits", 32'(mon_bits), FL);
        check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_exp = exp_q.pop_front();
          check("frame_mosi", 32'(mon_mosi), 32'(mon_exp.mosi));
          check("frame_miso", 32'(mon_miso), 32'(mon_exp.miso));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_done(input bit is_wr, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((is_wr ? bus.WR_DONE : bus.RD_DONE) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_write(input logic [DW-1:0] d);
    frame_t f;
    bit     seen;
    @(negedge clk);
    f.mosi = {CMD_WR, wptr, d};
    f.miso = '0;
    exp_q.push_back(f);
    bus.DIN      = d;
    bus.WR_START = 1'b1;
    wait_done(1'b1, seen);
    check("wr_done", 32'(seen), 32'd1);
    bus.WR_START = 1'b0;
    @(negedge clk);
    check("wr_done_pulse", 32'(bus.WR_DONE), 32'd0);
    ref_mem[wptr] = d;
    wptr++;
  endtask

  task automatic do_read();
    frame_t        f;
    bit            seen;
    logic [DW-1:0] e;
    @(negedge clk);
    f.mosi = {CMD_RD, rptr, {DW{1'b0}}};
    f.miso = {{(FL-DW){1'b0}}, ref_mem[rptr]};
    exp_q.push_back(f);
    dout_q.push_back(ref_mem[rptr]);
    bus.RD_START = 1'b1;
    wait_done(1'b0, seen);
    check("rd_done", 32'(seen), 32'd1);
    e = dout_q.pop_front();
    if (seen) check("dout", 32'(bus.DOUT), 32'(e));
    bus.RD_START = 1'b0;
    @(negedge clk);
    check("rd_done_pulse", 32'(bus.RD_DONE), 32'd0);
    rptr++;
  endtask

  int  wr_b, rd_b;
  bit  seen_main;

  initial begin
    bus.WR_START = 1'b0;
    bus.RD_START = 1'b0;
    bus.DIN      = '0;
    wptr = '0;
    rptr = '0;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_csn", 32'(bus.CSN), 32'd1);
    check("rst_sclk", 32'(bus.SCLK), 32'd0);
    check("rst_mosi", 32'(bus.MOSI), 32'd0);
    check("rst_miso", 32'(bus.MISO), 32'd0);
    check("rst_wr_done", 32'(bus.WR_DONE), 32'd0);
    check("rst_rd_done", 32'(bus.RD_DONE), 32'd0);
    check("rst_dout", 32'(bus.DOUT), 32'd0);
    rstn = 1'b1;

    // Read of cleared RAM, then fill and wrap the write pointer.
    do_read();
    for (int i = 0; i < 8; i++) do_write(DW'(i));
    do_write(4'd8);

    rd_b = rd_cnt;
    for (int i = 0; i < 9; i++) do_read();
    repeat (2) @(negedge clk);
    check("rd_done_count", 32'(rd_cnt - rd_b), 32'd9);

    // Held level plus a second edge while busy: one write only.
    wr_b = wr_cnt;
    begin
      frame_t f;
      f.mosi = {CMD_WR, wptr, 4'd9};
      f.miso = '0;
      exp_q.push_back(f);
    end
    @(negedge clk);
    bus.DIN      = 4'd9;
    bus.WR_START = 1'b1;
    repeat (10) @(negedge clk);
    bus.WR_START = 1'b0;
    repeat (3) @(negedge clk);
    bus.DIN      = 4'hF;
    bus.WR_START = 1'b1;
    repeat (5) @(negedge clk);
    bus.WR_START = 1'b0;
    wait_done(1'b1, seen_main);
    check("held_wr_done", 32'(seen_main), 32'd1);
    ref_mem[wptr] = 4'd9;
    wptr++;
    repeat (150) @(negedge clk);
    check("held_wr_count", 32'(wr_cnt - wr_b), 32'd1);

    // Simultaneous edges: write wins, read dropped.
    wr_b = wr_cnt;
    rd_b = rd_cnt;
    begin
      frame_t f;
      f.mosi = {CMD_WR, wptr, 4'd6};
      f.miso = '0;
      exp_q.push_back(f);
    end
    @(negedge clk);
    bus.DIN      = 4'd6;
    bus.WR_START = 1'b1;
    bus.RD_START = 1'b1;
    wait_done(1'b1, seen_main);
    check("both_wr_done", 32'(seen_main), 32'd1);
    bus.WR_START = 1'b0;
    bus.RD_START = 1'b0;
    ref_mem[wptr] = 4'd6;
    wptr++;
    repeat (120) @(negedge clk);
    check("both_wr_count", 32'(wr_cnt - wr_b), 32'd1);
    check("both_rd_count", 32'(rd_cnt - rd_b), 32'd0);

    // Reset in the middle of a write frame.
    @(negedge clk);
    bus.DIN      = 4'hA;
    bus.WR_START = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_csn_low", 32'(bus.CSN), 32'd0);
    #2;
    rstn         = 1'b0;
    bus.WR_START = 1'b0;
    #1;
    check("abort_csn", 32'(bus.CSN), 32'd1);
    check("abort_sclk", 32'(bus.SCLK), 32'd0);
    check("abort_mosi", 32'(bus.MOSI), 32'd0);
    wr_b = wr_cnt;
    repeat (5) @(negedge clk);
    check("abort_wr_done", 32'(bus.WR_DONE), 32'd0);
    check("abort_dout", 32'(bus.DOUT), 32'd0);
    rstn = 1'b1;
    wptr = '0;
    rptr = '0;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    repeat (100) @(negedge clk);
    check("abort_no_done", 32'(wr_cnt - wr_b), 32'd0);

    // Pointers restart at 0; read-after-write returns the new data.
    do_write(4'd3);
    do_read();
    do_read();

    repeat (20) @(negedge clk);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
